// File: rtl/clk_en_gen.sv
// clk_en_gen: lock-qualified fractional clock-enable generator.
// Qualifies the PLL lock, releases a synchronous core reset once lock is
// stable, then emits a phase-accumulator fractional enable plus
// power-of-two sub-enables.
//
// Ports:
//   clk           fast PLL output clock
//   reset         asynchronous active-high reset
//   lock          PLL lock (asynchronous to clk)
//   rst_out       synchronous core reset, active-high
//   running       high while in RUN
//   ce            single-cycle fractional enable (rate f_clk*INC/MOD)
//   ce_sub[k]     pulses on every 2**(k+1)-th ce pulse
//   lock_loss_cnt saturating count of RUN->WAIT_LOCK transitions
//
// Optional feature macro: CLK_EN_GEN_LOSS_CNT_EN
//   defined   : lock_loss_cnt counts lock losses, saturating at 255
//   undefined : lock_loss_cnt is tied to 8'd0
module clk_en_gen #(
    parameter int ACC_W       = 16,
    parameter int INC         = 32,
    parameter int MOD         = 1250,
    parameter int LOCK_FILTER = 1024,
    parameter int NUM_SUB     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lock,
    output logic               rst_out,
    output logic               running,
    output logic               ce,
    output logic [NUM_SUB-1:0] ce_sub,
    output logic [7:0]         lock_loss_cnt
);

    localparam int FW = $clog2(LOCK_FILTER + 1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_FILT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_sync1;
    logic               r_sync2;
    logic               w_lock_s;
    logic [FW-1:0]      r_cnt;
    logic [FW-1:0]      w_cnt_nx;
    logic               r_rst;
    logic               w_rst_nx;
    logic               r_running;
    logic               w_run_nx;
    logic               w_adv;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nx;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_wrap;
    logic               r_ce;
    logic               w_ce_nx;
    logic [NUM_SUB-1:0] r_sub;
    logic [NUM_SUB-1:0] w_sub_nx;
    logic [NUM_SUB-1:0] w_ones;
    logic [NUM_SUB-1:0] r_ce_sub;
    logic [NUM_SUB-1:0] w_ce_sub_nx;

    assign w_lock_s = r_sync2;

    // Two-flop synchroniser for the asynchronous lock input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= lock;
            r_sync2 <= r_sync1;
        end
    end

    // Lock qualification FSM: next state and registered outputs
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rst_nx   = r_rst;
        w_run_nx   = r_running;
        w_adv      = 1'b0;
        unique case (r_state)
            S_WAIT: begin
                w_rst_nx = 1'b1;
                w_run_nx = 1'b0;
                if (w_lock_s) begin
                    w_state_nx = S_FILT;
                    w_cnt_nx   = FW'(1);
                end
            end
            S_FILT: begin
                if (!w_lock_s) begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = '0;
                end else if (r_cnt == FW'(LOCK_FILTER)) begin
                    w_state_nx = S_RUN;
                    w_cnt_nx   = '0;
                    w_rst_nx   = 1'b0;
                    w_run_nx   = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + FW'(1);
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = '0;
                    w_rst_nx   = 1'b1;
                    w_run_nx   = 1'b0;
                end else begin
                    w_adv = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_WAIT;
                w_cnt_nx   = '0;
                w_rst_nx   = 1'b1;
                w_run_nx   = 1'b0;
            end
        endcase
    end

    // Phase accumulator; wrap result is exact in ACC_W bits since it
    // always lands in [0, MOD)
    assign w_sum  = {1'b0, r_acc} + (ACC_W + 1)'(INC);
    assign w_wrap = r_acc + ACC_W'(INC) - ACC_W'(MOD);

    always_comb begin
        logic all1;
        all1        = 1'b1;
        w_ones      = '0;
        w_acc_nx    = '0;
        w_ce_nx     = 1'b0;
        w_sub_nx    = '0;
        w_ce_sub_nx = '0;
        // w_ones[k] = &r_sub[k:0]
        for (int k = 0; k < NUM_SUB; k++) begin
            all1      = all1 & r_sub[k];
            w_ones[k] = all1;
        end
        if (w_adv) begin
            w_sub_nx = r_sub;
            if (w_sum >= (ACC_W + 1)'(MOD)) begin
                w_acc_nx    = w_wrap;
                w_ce_nx     = 1'b1;
                w_sub_nx    = r_sub + NUM_SUB'(1);
                w_ce_sub_nx = w_ones;
            end else begin
                w_acc_nx = w_sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_WAIT;
            r_cnt     <= '0;
            r_rst     <= 1'b1;
            r_running <= 1'b0;
            r_acc     <= '0;
            r_ce      <= 1'b0;
            r_sub     <= '0;
            r_ce_sub  <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_rst     <= w_rst_nx;
            r_running <= w_run_nx;
            r_acc     <= w_acc_nx;
            r_ce      <= w_ce_nx;
            r_sub     <= w_sub_nx;
            r_ce_sub  <= w_ce_sub_nx;
        end
    end

    assign rst_out = r_rst;
    assign running = r_running;
    assign ce      = r_ce;
    assign ce_sub  = r_ce_sub;

`ifdef CLK_EN_GEN_LOSS_CNT_EN
    logic       w_loss;
    logic [7:0] r_loss;

    assign w_loss = (r_state == S_RUN) && !w_lock_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_loss <= 8'd0;
        end else if (w_loss && (r_loss != 8'hFF)) begin
            r_loss <= r_loss + 8'd1;
        end
    end

    assign lock_loss_cnt = r_loss;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Testbench for clk_en_gen: scoreboard against a streak/arithmetic model.
// Second instance with a tiny filter exercises loss-counter saturation.
module tb_clk_en_gen;

    localparam int LF  = 1024;
    localparam int INC = 32;
    localparam int MOD = 1250;
    localparam int NS  = 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          lock  = 1'b0;
    logic          rst_out;
    logic          running;
    logic          ce;
    logic [NS-1:0] ce_sub;
    logic [7:0]    lock_loss_cnt;

    logic          lock2 = 1'b0;
    logic          rst2;
    logic          run2;
    logic          ce2;
    logic [2:0]    sub2;
    logic [7:0]    loss2;

    always #5 clk = ~clk;

    clk_en_gen dut (
        .clk          (clk),
        .reset        (reset),
        .lock         (lock),
        .rst_out      (rst_out),
        .running      (running),
        .ce           (ce),
        .ce_sub       (ce_sub),
        .lock_loss_cnt(lock_loss_cnt)
    );

    clk_en_gen #(
        .ACC_W      (16),
        .INC        (3),
        .MOD        (7),
        .LOCK_FILTER(1),
        .NUM_SUB    (3)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .lock         (lock2),
        .rst_out      (rst2),
        .running      (run2),
        .ce           (ce2),
        .ce_sub       (sub2),
        .lock_loss_cnt(loss2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input longint act,
                         input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: state follows from the count of consecutive
    // lock_s-high edges; RUN edge n yields a ce whenever floor(n*INC/MOD)
    // steps up, and that floor is the ce pulse number.
    typedef struct {
        longint c;
        int     sub;
    } ev_t;

    ev_t    q[$];
    bit     sh1, sh2;
    longint streak;
    int     losses;
    bit     exp_run;
    longint cyc = 0;

    function automatic int exp_loss();
`ifdef CLK_EN_GEN_LOSS_CNT_EN
        return losses;
`else
        return 0;
`endif
    endfunction

    task automatic do_reset(input bit v);
        reset = v;
        if (v) begin
            sh1     = 1'b0;
            sh2     = 1'b0;
            streak  = 0;
            losses  = 0;
            exp_run = 1'b0;
            q.delete();
        end
    endtask

    task automatic model_edge();
        bit     ls;
        bit     was;
        longint n;
        longint a;
        longint b;
        int     m;
        if (reset) return;
        ls  = sh2;
        sh2 = sh1;
        sh1 = lock;
        was = (streak >= LF + 1);
        streak = ls ? streak + 1 : 0;
        exp_run = (streak >= LF + 1);
        if (was && !exp_run)
            losses = (losses < 255) ? losses + 1 : 255;
        if (was && exp_run) begin
            n = streak - LF - 1;
            a = (n * INC) / MOD;
            b = ((n - 1) * INC) / MOD;
            if (a != b) begin
                m = 0;
                for (int k = 0; k < NS; k++)
                    if ((a % (longint'(2) << k)) == 0) m |= (1 << k);
                q.push_back('{c: cyc, sub: m});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
    endtask

    // Monitor: compares status every cycle, pops on each ce pulse
    always @(negedge clk) begin
        ev_t e;
        check("status", {rst_out, running, lock_loss_cnt},
              {!exp_run, exp_run, 8'(exp_loss())});
        if (ce) begin
            if (q.size() == 0) begin
                check("ce_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                check("ce_cycle", cyc, e.c);
                check("ce_sub", longint'(ce_sub), e.sub);
            end
        end else begin
            check("ce_sub_idle", longint'(ce_sub), 0);
            if (q.size() != 0) check("ce_missing", q[0].c < cyc, 0);
        end
    end

    initial begin
        int first;
        int nce;
        int last;
        int badgap;
        int ns0;
        int ns1;
        int cnt;
        bit found;
        int tce2;
        int tsub0;
        int viol;

        lock = 1'b1;
        do_reset(1'b1);
        repeat (3) step();
        check("reset_outputs",
              {rst_out, running, ce, ce_sub, lock_loss_cnt},
              {1'b1, 1'b0, 1'b0, 2'b00, 8'd0});
        do_reset(1'b0);

        // Steady lock: release on edge 2+1+1024
        for (int i = 1; i <= 1027; i++) begin
            step();
            if (i == 1026) check("pre_release_running", running, 0);
        end
        check("release_running", running, 1);
        check("release_rst_out", rst_out, 0);

        // One MOD window of RUN
        first = -1; nce = 0; last = 0; badgap = 0; ns0 = 0; ns1 = 0;
        for (int i = 1; i <= MOD; i++) begin
            step();
            if (ce) begin
                nce++;
                if (first < 0) first = i;
                else if ((i - last) != 39 && (i - last) != 40) badgap++;
                last = i;
                if (nce <= 16) begin
                    ns0 += int'(ce_sub[0]);
                    ns1 += int'(ce_sub[1]);
                end
            end
        end
        check("first_ce_edge", first, 40);
        check("ce_per_window", nce, INC);
        check("ce_gap", badgap, 0);
        check("ce_sub0_in_16", ns0, 8);
        check("ce_sub1_in_16", ns1, 4);

        // Lock drops for 5 cycles in RUN
        lock = 1'b0;
        step();
        step();
        check("drop_lag_running", running, 1);
        step();
        check("drop_outputs", {rst_out, running, ce}, 3'b100);
        step();
        step();
        lock = 1'b1;
        cnt = 0; found = 1'b0;
        for (int i = 1; i <= 1100 && !found; i++) begin
            step();
            cnt = i;
            if (running) found = 1'b1;
        end
        check("relock_found", found, 1);
        check("relock_edges", cnt, 1027);
        first = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (ce && first < 0) first = i;
        end
        check("relock_first_ce", first, 40);
`ifdef CLK_EN_GEN_LOSS_CNT_EN
        check("loss_after_drop", lock_loss_cnt, 1);
`else
        check("loss_after_drop", lock_loss_cnt, 0);
`endif

        // 1-cycle glitch at filter count 500
        do_reset(1'b1);
        step();
        do_reset(1'b0);
        for (int i = 1; i <= 1530; i++) begin
            step();
            if (i == 502) lock = 1'b0;
            if (i == 503) lock = 1'b1;
            if (i == 1529) check("glitch_no_early", running, 0);
        end
        check("glitch_release", running, 1);

        // Async reset mid-RUN
        repeat (100) step();
        #2;
        do_reset(1'b1);
        #1;
        check("async_reset_outputs",
              {rst_out, running, ce, ce_sub, lock_loss_cnt},
              {1'b1, 1'b0, 1'b0, 2'b00, 8'd0});
        repeat (2) step();
        do_reset(1'b0);

        // Random lock behaviour with occasional resets
        cnt = 1500;
        for (int i = 0; i < 20000; i++) begin
            step();
            if ($urandom_range(0, 4999) == 0) begin
                do_reset(1'b1);
                step();
                do_reset(1'b0);
            end
            if (cnt == 0) begin
                lock = ~lock;
                cnt = lock ? int'($urandom_range(200, 3000))
                           : int'($urandom_range(1, 6));
            end else begin
                cnt--;
            end
        end

        // Loss-counter saturation on the small-filter instance
        tce2 = 0; tsub0 = 0; viol = 0;
        for (int i = 0; i < 300; i++) begin
            lock2 = 1'b1;
            for (int j = 0; j < 8; j++) begin
                step();
                tce2  += int'(ce2);
                tsub0 += int'(sub2[0]);
                if ((!ce2 && sub2 != 3'd0) || sub2[2:1] != 2'd0) viol++;
            end
            check("sat_running", {run2, rst2}, 2'b10);
            lock2 = 1'b0;
            for (int j = 0; j < 5; j++) begin
                step();
                tce2  += int'(ce2);
                tsub0 += int'(sub2[0]);
                if ((!ce2 && sub2 != 3'd0) || sub2[2:1] != 2'd0) viol++;
            end
`ifdef CLK_EN_GEN_LOSS_CNT_EN
            check("sat_loss", loss2, (i + 1 < 255) ? i + 1 : 255);
`else
            check("sat_loss", loss2, 0);
`endif
        end
        check("sat_ce2_total", tce2, 600);
        check("sat_sub0_total", tsub0, 300);
        check("sat_sub_viol", viol, 0);

        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
